seq_alu_module: RTL and testbench



---
 rtl/seq_alu_module.sv | 191 +++++++++++++++++++
 tb/tb_seq_alu_module.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seq_alu_module.sv
// Multi-cycle ALU feeding the LED results decoder: single-cycle logic/arith ops,
// iterative shift-add MUL and restoring DIV. Define SEQ_ALU_DIV_EN to build the divider.
module seq_alu_module #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] temp_results,
   output logic             zero,
   output logic             carry,
   output logic             overflow,
   output logic             error
);

   // state | meaning
   // IDLE  | waiting for start, outputs hold last committed result
   // EXEC  | single-cycle op, commit on leaving
   // ITER  | one MUL/DIV step per cycle, commit on the last step
   // DONE  | done pulse, back to IDLE next
   typedef enum logic [1:0] {IDLE, EXEC, ITER, DONE} state_t;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;
   localparam logic [2:0] OP_DIV = 3'b111;

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t state, state_n;

   logic [WIDTH-1:0]   a_q, b_q;
   logic [2:0]         op_q;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] p, p_step;

   logic go_iter;
   logic last_step;

   logic [WIDTH:0]     sum, dif, acc;
   logic [2*WIDTH-1:0] shl;
   logic [WIDTH-1:0]   res_e;
   logic               c_e, v_e, e_e;

   logic               commit;
   logic [WIDTH-1:0]   res_c;
   logic               c_c, v_c, e_c;

   always_comb begin
      go_iter = (op == OP_MUL);
`ifdef SEQ_ALU_DIV_EN
      if ((op == OP_DIV) && (b != '0)) go_iter = 1'b1;
`endif
   end

   assign last_step = (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = go_iter ? ITER : EXEC;
         EXEC:    state_n = DONE;
         ITER:    if (last_step) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   // DIV lands here only for b==0 or when the divider is not built
   always_comb begin
      sum   = {1'b0, a_q} + {1'b0, b_q};
      dif   = {1'b0, a_q} - {1'b0, b_q};
      shl   = {{WIDTH{1'b0}}, a_q} << b_q[1:0];
      res_e = '0;
      c_e   = 1'b0;
      v_e   = 1'b0;
      e_e   = 1'b0;
      case (op_q)
         OP_ADD: begin
            res_e = sum[WIDTH-1:0];
            c_e   = sum[WIDTH];
            v_e   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_SUB: begin
            res_e = dif[WIDTH-1:0];
            c_e   = dif[WIDTH];
            v_e   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dif[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_AND: res_e = a_q & b_q;
         OP_OR:  res_e = a_q | b_q;
         OP_XOR: res_e = a_q ^ b_q;
         OP_SHL: begin
            res_e = shl[WIDTH-1:0];
            c_e   = |shl[2*WIDTH-1:WIDTH];
         end
         OP_DIV: begin
            res_e = '1;
            e_e   = 1'b1;
         end
         default: res_e = '0;
      endcase
   end

   // p holds {partial product, multiplier} for MUL, {remainder, dividend/quotient} for DIV
`ifdef SEQ_ALU_DIV_EN
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] rem_dif;
   logic             ge;
`endif
   always_comb begin
      acc    = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
      p_step = {acc, p[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
      rem_sh  = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
      ge      = (rem_sh >= {1'b0, b_q});
      rem_dif = rem_sh[WIDTH-1:0] - b_q;
      if (op_q == OP_DIV)
         p_step = {(ge ? rem_dif : rem_sh[WIDTH-1:0]), p[WIDTH-2:0], ge};
`endif
   end

   always_comb begin
      commit = 1'b0;
      res_c  = res_e;
      c_c    = c_e;
      v_c    = v_e;
      e_c    = e_e;
      if (state == EXEC) begin
         commit = 1'b1;
      end else if ((state == ITER) && last_step) begin
         commit = 1'b1;
         res_c  = p_step[WIDTH-1:0];
         c_c    = (op_q == OP_MUL) ? (|p_step[2*WIDTH-1:WIDTH]) : 1'b0;
         v_c    = 1'b0;
         e_c    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= '0;
         cnt          <= '0;
         p            <= '0;
         temp_results <= '0;
         zero         <= 1'b0;
         carry        <= 1'b0;
         overflow     <= 1'b0;
         error        <= 1'b0;
      end else begin
         if ((state == IDLE) && start) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op;
            cnt  <= '0;
            p    <= {{WIDTH{1'b0}}, ((op == OP_MUL) ? b : a)};
         end
         if (state == ITER) begin
            p   <= p_step;
            cnt <= cnt + 1'b1;
         end
         if (commit) begin
            temp_results <= res_c;
            zero         <= (res_c == '0);
            carry        <= c_c;
            overflow     <= v_c;
            error        <= e_c;
         end
      end
   end

endmodule

// File: tb/tb_seq_alu_module.sv
// Directed bench for seq_alu_module (WIDTH=4); DIV expectations follow SEQ_ALU_DIV_EN.
module tb_seq_alu_module;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [2:0] op;
   logic [3:0] a, b;
   logic       busy, done, zero, carry, overflow, error;
   logic [3:0] temp_results;

   int checks = 0;
   int errors = 0;
   int lat, bc, dc;

   seq_alu_module #(.WIDTH(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .op           (op),
      .a            (a),
      .b            (b),
      .busy         (busy),
      .done         (done),
      .temp_results (temp_results),
      .zero         (zero),
      .carry        (carry),
      .overflow     (overflow),
      .error        (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_flags(input string tag, input logic [3:0] r, input logic z,
                              input logic c, input logic v, input logic e);
      check({tag, ".result"},   temp_results, r);
      check({tag, ".zero"},     zero, z);
      check({tag, ".carry"},    carry, c);
      check({tag, ".overflow"}, overflow, v);
      check({tag, ".error"},    error, e);
   endtask

   // E0 is the posedge that samples start; samples are taken 1 time unit after each edge
   task automatic run_op(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y,
                         input int inj, output int l, output int busy_cyc, output int done_cnt);
      @(negedge clk);
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; a = ~x; b = ~y; op = ~o;
      l = -1; busy_cyc = 0; done_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         if (i > 0) begin
            @(posedge clk);
            #1;
         end
         if (busy) busy_cyc++;
         if (done) begin
            done_cnt++;
            if (l < 0) l = i;
         end
         start = (i == inj);
      end
      start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.busy", busy, 0);
      check("rst.done", done, 0);
      check_flags("rst", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(3'b000, 4'd9, 4'd8, -1, lat, bc, dc);
      check_flags("add9_8", 4'd1, 1'b0, 1'b1, 1'b1, 1'b0);
      check("add9_8.latency", lat, 1);
      check("add9_8.busy_cycles", bc, 2);
      check("add9_8.done_count", dc, 1);
      repeat (3) @(posedge clk);
      #1;
      check("hold.result", temp_results, 4'd1);
      check("hold.done", done, 0);

      run_op(3'b001, 4'd3, 4'd5, -1, lat, bc, dc);
      check_flags("sub3_5", 4'd14, 1'b0, 1'b1, 1'b0, 1'b0);
      run_op(3'b001, 4'd6, 4'd6, -1, lat, bc, dc);
      check_flags("sub6_6", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      run_op(3'b001, 4'd7, 4'd15, -1, lat, bc, dc);
      check_flags("sub7_m1", 4'd8, 1'b0, 1'b1, 1'b1, 1'b0);

      run_op(3'b010, 4'hC, 4'hA, -1, lat, bc, dc);
      check("and.result", temp_results, 4'h8);
      run_op(3'b011, 4'hC, 4'hA, -1, lat, bc, dc);
      check("or.result", temp_results, 4'hE);
      run_op(3'b100, 4'hA, 4'h6, -1, lat, bc, dc);
      check_flags("xor", 4'hC, 1'b0, 1'b0, 1'b0, 1'b0);

      run_op(3'b101, 4'hB, 4'd2, -1, lat, bc, dc);
      check_flags("shl_b_2", 4'hC, 1'b0, 1'b1, 1'b0, 1'b0);
      run_op(3'b101, 4'h3, 4'd5, -1, lat, bc, dc);
      check_flags("shl_3_1", 4'h6, 1'b0, 1'b0, 1'b0, 1'b0);

      run_op(3'b110, 4'd5, 4'd3, -1, lat, bc, dc);
      check_flags("mul5_3", 4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
      check("mul5_3.latency", lat, 4);
      check("mul5_3.busy_cycles", bc, 5);
      run_op(3'b110, 4'd7, 4'd6, -1, lat, bc, dc);
      check_flags("mul7_6", 4'd10, 1'b0, 1'b1, 1'b0, 1'b0);
      check("mul7_6.latency", lat, 4);
      check("mul7_6.busy_cycles", bc, 5);
      check("mul7_6.done_count", dc, 1);

`ifdef SEQ_ALU_DIV_EN
      run_op(3'b111, 4'd13, 4'd4, -1, lat, bc, dc);
      check_flags("div13_4", 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      check("div13_4.latency", lat, 4);
      run_op(3'b111, 4'd7, 4'd0, -1, lat, bc, dc);
      check_flags("div7_0", 4'd15, 1'b0, 1'b0, 1'b0, 1'b1);
      check("div7_0.latency", lat, 1);
`else
      run_op(3'b111, 4'd13, 4'd4, -1, lat, bc, dc);
      check_flags("div_off", 4'd15, 1'b0, 1'b0, 1'b0, 1'b1);
      check("div_off.latency", lat, 1);
`endif

      run_op(3'b110, 4'd3, 4'd3, 2, lat, bc, dc);
      check("mul_inj.result", temp_results, 4'd9);
      check("mul_inj.done_count", dc, 1);
      check("mul_inj.latency", lat, 4);
      check("mul_inj.busy_end", busy, 0);

      @(negedge clk);
      op = 3'b110; a = 4'd7; b = 4'd6; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_mid.busy", busy, 0);
      check("rst_mid.done", done, 0);
      check_flags("rst_mid", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      dc = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (done) dc++;
      end
      check("rst_mid.no_done", dc, 0);
      check("rst_mid.result_after", temp_results, 4'd0);

      run_op(3'b000, 4'd2, 4'd2, -1, lat, bc, dc);
      check_flags("add2_2", 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
      check("add2_2.latency", lat, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
